// File: rtl/led_target_generator.sv
// rtl/led_target_generator.sv - LED reaction game target generator with response timing
// Lights one pseudo-random LED per round and reports hit/miss pulses over a fixed number of rounds.
module led_target_generator #(
    parameter int          NUM_LEDS    = 18,
    parameter int          SHOW_CYCLES = 50_000_000,
    parameter int          GAP_CYCLES  = 12_500_000,
    parameter int          NUM_ROUNDS  = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] switches,
    output logic [NUM_LEDS-1:0] leds,
    output logic                hit,
    output logic                miss,
    output logic [7:0]          round_cnt,
    output logic                busy,
    output logic                done
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW = $clog2(MAX_CYCLES + 1);
    localparam int IW = $clog2(NUM_LEDS);

    localparam logic [TW-1:0]       SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0]       GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]          ROUNDS    = 8'(NUM_ROUNDS);
    localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);
    localparam logic [15:0]         LFSR_TAPS = 16'hB400;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PICK = 3'd1;
    localparam logic [2:0] S_SHOW = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [IW-1:0]       target_q, target_d;
    logic [IW-1:0]       prev_idx_q, prev_idx_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic [7:0]          round_q, round_d;
    logic                busy_q, done_q;

    logic [NUM_LEDS-1:0] sync1_q, sync2_q, sw_prev_q, sw_rise_q;
    logic [IW-1:0]       candidate;

    // Right-shifting Galois form never maps a non-zero state to zero.
    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign candidate = IW'(lfsr_q % 16'(NUM_LEDS));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        target_d   = target_q;
        prev_idx_d = prev_idx_q;
        leds_d     = leds_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        round_d    = round_q;
        case (state_q)
            S_IDLE: begin
                leds_d = '0;
                if (start) begin
                    state_d = S_PICK;
                    round_d = 8'd0;
                end
            end
            S_PICK: begin
                if (candidate != prev_idx_q) begin
                    target_d   = candidate;
                    prev_idx_d = candidate;
                    timer_d    = '0;
                    leds_d     = LED_ONE << candidate;
                    state_d    = S_SHOW;
                end
            end
            S_SHOW: begin
                timer_d = timer_q + 1'b1;
                // A hit on the final SHOW clock takes priority over the timeout.
                if (sw_rise_q[target_q]) begin
                    hit_d   = 1'b1;
                    round_d = round_q + 8'd1;
                    timer_d = '0;
                    leds_d  = '0;
                    state_d = S_GAP;
                end else if (timer_q == SHOW_LAST) begin
                    miss_d  = 1'b1;
                    round_d = round_q + 8'd1;
                    timer_d = '0;
                    leds_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                leds_d  = '0;
                timer_d = timer_q + 1'b1;
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = (round_q == ROUNDS) ? S_DONE : S_PICK;
                end
            end
            S_DONE: begin
                leds_d = '0;
                if (start) begin
                    round_d = 8'd0;
                    state_d = S_PICK;
                end
            end
            default: begin
                state_d = S_IDLE;
                leds_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_prev_q <= '0;
            sw_rise_q <= '0;
        end else begin
            sync1_q   <= switches;
            sync2_q   <= sync1_q;
            sw_prev_q <= sync2_q;
            sw_rise_q <= sync2_q & ~sw_prev_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            target_q   <= '0;
            prev_idx_q <= IW'(NUM_LEDS - 1);
            leds_q     <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            round_q    <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lfsr_q     <= lfsr_d;
            target_q   <= target_d;
            prev_idx_q <= prev_idx_d;
            leds_q     <= leds_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            round_q    <= round_d;
            busy_q     <= (state_d == S_PICK) || (state_d == S_SHOW) || (state_d == S_GAP);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign leds      = leds_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign round_cnt = round_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_led_target_generator.sv
// tb/tb_led_target_generator.sv - self-checking bench for led_target_generator
// Round-level reference model: expected hit/miss, LED window and counters derive from the stimulus timing.
module tb_led_target_generator;

    localparam int N      = 18;
    localparam int SHOW   = 20;
    localparam int GAP    = 5;
    localparam int ROUNDS = 3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] switches = '0;
    logic [N-1:0] leds;
    logic         hit, miss, busy, done;
    logic [7:0]   round_cnt;

    int           tests = 0;
    int           fails = 0;
    int           prev_tgt;
    int           rounds_done;
    logic [N-1:0] base_sw;

    led_target_generator #(
        .NUM_LEDS    (N),
        .SHOW_CYCLES (SHOW),
        .GAP_CYCLES  (GAP),
        .NUM_ROUNDS  (ROUNDS),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .switches  (switches),
        .leds      (leds),
        .hit       (hit),
        .miss      (miss),
        .round_cnt (round_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_show(output int tgt);
        tgt = -1;
        for (int k = 0; k < 100 && leds == '0; k++) @(negedge clk);
        check("show_timeout", 64'(leds != '0), 64'd1);
        for (int i = 0; i < N; i++) if (leds[i]) tgt = i;
        if (tgt < 0) tgt = 0;
    endtask

    // mode 0: untouched, 1: raise target at SHOW cycle c, 2: pulse a non-target switch, 3: start in SHOW
    task automatic run_round(input int mode, input int c);
        int           tgt, nt, endc;
        logic         exp_hit;
        logic [N-1:0] onehot;
        wait_show(tgt);
        check("onehot", 64'($countones(leds)), 64'd1);
        check("no_repeat", 64'(tgt != prev_tgt), 64'd1);
        check("busy_show", 64'(busy), 64'd1);
        check("rcnt_show", 64'(round_cnt), 64'(rounds_done));
        prev_tgt = tgt;
        onehot = '0;
        onehot[tgt] = 1'b1;
        nt = (tgt + 1 + int'($urandom_range(0, N - 2))) % N;
        exp_hit = (mode == 1) && (c <= SHOW - 4);
        endc = exp_hit ? c + 4 : SHOW;
        for (int k = 0; k < endc; k++) begin
            check("show_hold", 64'({leds, hit, miss}), 64'({onehot, 2'b00}));
            if (k == c) begin
                if (mode == 1) switches[tgt] = 1'b1;
                if (mode == 2) switches[nt] = ~base_sw[nt];
                if (mode == 3) start = 1'b1;
            end
            if (k == c + 1 && mode == 3) start = 1'b0;
            if (k == c + 4 && mode == 2) switches[nt] = base_sw[nt];
            @(negedge clk);
        end
        start = 1'b0;
        check("end_pulse", 64'({hit, miss}), 64'({exp_hit, ~exp_hit}));
        check("end_leds", 64'(leds), 64'd0);
        check("end_rcnt", 64'(round_cnt), 64'(rounds_done + 1));
        rounds_done++;
        switches = base_sw;
        for (int k = 1; k < GAP; k++) begin
            @(negedge clk);
            check("gap_dark", 64'({leds, hit, miss}), 64'd0);
            check("gap_busy", 64'(busy), 64'd1);
        end
    endtask

    task automatic run_game(input int held, input int force_mode, input int force_c);
        int mode, c;
        base_sw = held != 0 ? '1 : '0;
        switches = base_sw;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rounds_done = 0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_rcnt", 64'(round_cnt), 64'd0);
        check("start_done", 64'(done), 64'd0);
        for (int r = 0; r < ROUNDS; r++) begin
            if (force_mode >= 0) mode = force_mode;
            else if (held != 0) mode = (int'($urandom_range(0, 2)) == 0) ? 0 : 2 + int'($urandom_range(0, 1));
            else mode = int'($urandom_range(0, 3));
            c = (mode == 2) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, SHOW - 1));
            if (force_c >= 0) c = force_c;
            run_round(mode, c);
        end
        @(negedge clk);
        check("done_flag", 64'({done, busy}), 64'b10);
        check("done_rcnt", 64'(round_cnt), 64'(ROUNDS));
        repeat (3) @(negedge clk);
        check("done_hold", 64'({done, round_cnt, leds}), 64'({1'b1, 8'(ROUNDS), {N{1'b0}}}));
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 100; k++) begin
            switches = N'($urandom());
            @(negedge clk);
            check("idle_quiet", 64'({leds, hit, miss, busy, done, round_cnt}), 64'd0);
        end
        switches = '0;
        prev_tgt = N - 1;

        run_game(0, 0, -1);
        run_game(0, 1, -1);
        run_game(0, 1, SHOW - 4);
        run_game(0, 1, SHOW - 3);
        run_game(1, -1, -1);
        for (int g = 0; g < 20; g++) run_game(0, -1, -1);

        base_sw = '0;
        switches = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_show(t);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_state", 64'({leds, hit, miss, busy, done, round_cnt}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        prev_tgt = N - 1;
        repeat (5) @(negedge clk);
        check("abort_idle", 64'({leds, busy, done, round_cnt}), 64'd0);
        run_game(0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
